// File: rtl/sm3_pkg.sv
// SM3 shared constants, types and word-level helpers.
// Used by sm3_compress and sm3_msg_expand.
package sm3_pkg;

  localparam logic [255:0] SM3_IV = {
    32'h7380166F, 32'h4914B2B9, 32'h172442D7, 32'hDA8A0600,
    32'hA96F30BC, 32'h163138AA, 32'hE38DEE4D, 32'hB0FB0E4E
  };

  localparam logic [31:0] T_LO = 32'h79CC4519;
  localparam logic [31:0] T_HI = 32'h7A879D8A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } sm3_state_e;

  // Working registers A..H; A sits in the top word so {A..H} maps onto v_in directly.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } sm3_regs_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
  endfunction

  function automatic logic [31:0] ff_j(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic hi);
    return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
  endfunction

  function automatic logic [31:0] gg_j(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic hi);
    return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
  endfunction

  // Next message word from a window whose index 0 is W[n]; returns W[n+16].
  function automatic logic [31:0] expand_word(input logic [31:0] w0, input logic [31:0] w3,
                                              input logic [31:0] w7, input logic [31:0] w10,
                                              input logic [31:0] w13);
    return p1(w0 ^ w7 ^ rotl32(w13, 5'd15)) ^ rotl32(w3, 5'd7) ^ w10;
  endfunction

endpackage

// File: rtl/sm3_msg_expand.sv
// SM3 message expansion: a 16-word sliding window holding Wj..Wj+15.
// With SM3_UNROLL2_EN defined the window advances two words per shift.
module sm3_msg_expand
  import sm3_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] b_in,
  output logic [31:0]  w_j,
  output logic [31:0]  w_j4
`ifdef SM3_UNROLL2_EN
  ,
  output logic [31:0]  w_j1,
  output logic [31:0]  w_j5
`endif
);

  logic [31:0] r_w [16];
  logic [31:0] w_new0;
`ifdef SM3_UNROLL2_EN
  logic [31:0] w_new1;
`endif

  // Next word(s) entering the window; W[j+17] only needs W[j+1..j+14], so both are independent.
  always_comb begin
    w_new0 = expand_word(r_w[0], r_w[3], r_w[7], r_w[10], r_w[13]);
`ifdef SM3_UNROLL2_EN
    w_new1 = expand_word(r_w[1], r_w[4], r_w[8], r_w[11], r_w[14]);
`endif
  end

  // Window register: load the block on accept, slide on every active round cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) r_w[i] <= b_in[511-32*i -: 32];
    end else if (shift) begin
`ifdef SM3_UNROLL2_EN
      for (int i = 0; i < 14; i++) r_w[i] <= r_w[i+2];
      r_w[14] <= w_new0;
      r_w[15] <= w_new1;
`else
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_new0;
`endif
    end
  end

  assign w_j  = r_w[0];
  assign w_j4 = r_w[4];
`ifdef SM3_UNROLL2_EN
  assign w_j1 = r_w[1];
  assign w_j5 = r_w[5];
`endif

endmodule

// File: rtl/sm3_compress.sv
// SM3 compression function CF(V, B) with a start/ready/done handshake.
// Optional build macro SM3_UNROLL2_EN: two rounds per clock (33-cycle latency instead of 65).
//
// state    | meaning
// ST_IDLE  | ready for a request; v_out holds the previous result
// ST_ROUND | rounds in progress; once r_j reaches 64 the result is registered
// ST_DONE  | single-cycle done pulse with v_out valid
module sm3_compress
  import sm3_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] v_in,
  input  logic [511:0] b_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] v_out
);

`ifdef SM3_UNROLL2_EN
  localparam logic [6:0] J_STEP = 7'd2;
`else
  localparam logic [6:0] J_STEP = 7'd1;
`endif

  sm3_state_e  r_state, w_next_state;
  logic [6:0]  r_j;
  logic [255:0] r_vreg;
  sm3_regs_t   r_ws;
  logic [255:0] r_v_out;
  sm3_regs_t   w_round_out;
  logic        w_accept;
  logic        w_round_active;
  logic        w_finish;
  logic [31:0] w_j, w_j4;
`ifdef SM3_UNROLL2_EN
  logic [31:0] w_j1, w_j5;
  sm3_regs_t   w_mid;
`endif

  function automatic sm3_regs_t sm3_round(input sm3_regs_t s, input logic [5:0] j,
                                          input logic [31:0] wj, input logic [31:0] wj4);
    logic        hi;
    logic [31:0] tj, a12, ss1, ss2, tt1, tt2;
    sm3_regs_t   n;
    hi  = (j >= 6'd16);
    tj  = hi ? T_HI : T_LO;
    a12 = rotl32(s.a, 5'd12);
    ss1 = rotl32(a12 + s.e + rotl32(tj, j[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    tt1 = ff_j(s.a, s.b, s.c, hi) + s.d + ss2 + (wj ^ wj4);
    tt2 = gg_j(s.e, s.f, s.g, hi) + s.h + ss1 + wj;
    n.a = tt1;
    n.b = s.a;
    n.c = rotl32(s.b, 5'd9);
    n.d = s.c;
    n.e = p0(tt2);
    n.f = s.e;
    n.g = rotl32(s.f, 5'd19);
    n.h = s.g;
    return n;
  endfunction

  assign w_accept       = (r_state == ST_IDLE) && start;
  assign w_round_active = (r_state == ST_ROUND) && !r_j[6];
  assign w_finish       = (r_state == ST_ROUND) && r_j[6];

  sm3_msg_expand u_msg_expand (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_accept),
    .shift (w_round_active),
    .b_in  (b_in),
    .w_j   (w_j),
`ifdef SM3_UNROLL2_EN
    .w_j1  (w_j1),
    .w_j5  (w_j5),
`endif
    .w_j4  (w_j4)
  );

  // Round datapath for the current j (and j+1 chained when unrolled).
  always_comb begin
`ifdef SM3_UNROLL2_EN
    w_mid       = sm3_round(r_ws, r_j[5:0], w_j, w_j4);
    w_round_out = sm3_round(w_mid, r_j[5:0] | 6'd1, w_j1, w_j5);
`else
    w_round_out = sm3_round(r_ws, r_j[5:0], w_j, w_j4);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_next_state = ST_ROUND;
      end
      ST_ROUND: begin
        busy = 1'b1;
        if (r_j[6]) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Working registers, round counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_j     <= '0;
      r_vreg  <= '0;
      r_ws    <= '0;
      r_v_out <= '0;
    end else if (w_accept) begin
      r_j    <= '0;
      r_vreg <= v_in;
      r_ws   <= v_in;
    end else if (w_round_active) begin
      r_ws <= w_round_out;
      r_j  <= r_j + J_STEP;
    end else if (w_finish) begin
      r_v_out <= r_ws ^ r_vreg;
      r_j     <= '0;
    end
  end

  assign v_out = r_v_out;

endmodule

// File: tb/tb_sm3_compress.sv
// Scoreboard bench for sm3_compress: stimulus pushes expected digests and accept
// times; a monitor pops and compares whenever done is presented.
module tb_sm3_compress;

`ifdef SM3_UNROLL2_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif

  localparam logic [255:0] TB_IV = {
    32'h7380166F, 32'h4914B2B9, 32'h172442D7, 32'hDA8A0600,
    32'hA96F30BC, 32'h163138AA, 32'hE38DEE4D, 32'hB0FB0E4E
  };
  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] D_ABC   = {32'h66C7F0F4, 32'h62EEEDD9, 32'hD1F2D46B, 32'hDC10E4E2,
                                      32'h4167C487, 32'h5CF2F7A2, 32'h297DA02B, 32'h8F4BA8E0};
  localparam logic [511:0] B_ABCD1 = {16{32'h61626364}};
  localparam logic [511:0] B_ABCD2 = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [255:0] D_ABCD  = {32'hDEBE9FF9, 32'h2275B8A1, 32'h38604889, 32'hC18E5A4D,
                                      32'h6FDB70E5, 32'h387E5765, 32'h293DCBA3, 32'h9C0C5732};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] v_in;
  logic [511:0] b_in;
  logic         ready, busy, done;
  logic [255:0] v_out;

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_done = 0;
  logic [255:0] q_exp[$];
  int           q_acc[$];

  sm3_compress dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .v_in  (v_in),
    .b_in  (b_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .v_out (v_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  function automatic logic [31:0] p0m(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction

  function automatic logic [31:0] p1m(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  // Reference CF: full 68-word expansion, then 64 rounds, then XOR with V.
  function automatic logic [255:0] cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w[68];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, fx, gx;
    for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1m(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79CC4519 : 32'h7A879D8A;
      ss1 = rl(rl(a, 12) + e + rl(t, j), 7);
      ss2 = ss1 ^ rl(a, 12);
      if (j < 16) begin
        fx = a ^ bb ^ c;
        gx = e ^ f ^ g;
      end else begin
        fx = (a & bb) | (a & c) | (bb & c);
        gx = (e & f) | (~e & g);
      end
      tt1 = fx + d + ss2 + (w[j] ^ w[j+4]);
      tt2 = gx + h + ss1 + w[j];
      d  = c;
      c  = rl(bb, 9);
      bb = a;
      a  = tt1;
      h  = g;
      g  = rl(f, 19);
      f  = e;
      e  = p0m(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; waits for ready, drives one request, drops start a cycle later.
  task automatic issue(input logic [255:0] v, input logic [511:0] b, input logic [255:0] e);
    int t;
    t = 0;
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk("ready_timeout", {255'd0, ready}, 256'd1);
    v_in  = v;
    b_in  = b;
    start = 1'b1;
    q_exp.push_back(e);
    q_acc.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 200);
    if (!done) chk("done_timeout", {255'd0, done}, 256'd1);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : mon
    logic [255:0] e;
    int k;
    if (rst_n && done) begin
      n_done++;
      if (q_exp.size() == 0) begin
        chk("unexpected_done", 256'd1, 256'd0);
      end else begin
        e = q_exp.pop_front();
        k = q_acc.pop_front();
        chk("digest", v_out, e);
        chk("latency", 256'(cyc - k), 256'(LAT));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] e1, prev, rv, gv;
    logic [511:0] rb, gb;
    int nd0, rdy_seen, t;

    rst_n = 1'b0;
    start = 1'b0;
    v_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {255'd0, ready}, 256'd1);
    chk("rst_busy",  {255'd0, busy},  256'd0);
    chk("rst_done",  {255'd0, done},  256'd0);
    chk("rst_v_out", v_out, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc" single block
    issue(TB_IV, B_ABC, D_ABC);
    wait_done();

    // "abcd"x16, chained blocks, issued back-to-back
    @(negedge clk);
    chk("hold_abc", v_out, D_ABC);
    chk("ready_after_done", {255'd0, ready}, 256'd1);
    e1 = cf(TB_IV, B_ABCD1);
    issue(TB_IV, B_ABCD1, e1);
    wait_done();
    @(negedge clk);
    issue(e1, B_ABCD2, D_ABCD);
    wait_done();

    // start held high with garbage for the whole "abc" run
    @(negedge clk);
    v_in  = TB_IV;
    b_in  = B_ABC;
    start = 1'b1;
    q_exp.push_back(D_ABC);
    q_acc.push_back(cyc + 1);
    nd0 = n_done;
    rdy_seen = 0;
    t = 0;
    do begin
      @(negedge clk);
      v_in = rnd256();
      b_in = rnd512();
      if (ready) rdy_seen++;
      t++;
    end while (!done && t < 200);
    chk("ready_during_run", 256'(rdy_seen), 256'd0);
    @(negedge clk);
    chk("one_done", 256'(n_done - nd0), 256'd1);
    chk("ready_reaccept", {255'd0, ready}, 256'd1);
    gv = rnd256();
    gb = rnd512();
    v_in = gv;
    b_in = gb;
    q_exp.push_back(cf(gv, gb));
    q_acc.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_reaccept", {255'd0, busy}, 256'd1);
    wait_done();

    // reset mid-run around round 30
    @(negedge clk);
    issue(TB_IV, B_ABC, D_ABC);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    q_exp.delete();
    q_acc.delete();
    #1;
    chk("midrst_ready", {255'd0, ready}, 256'd1);
    chk("midrst_busy",  {255'd0, busy},  256'd0);
    chk("midrst_done",  {255'd0, done},  256'd0);
    chk("midrst_v_out", v_out, 256'd0);
    nd0 = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("no_done_after_reset", 256'(n_done - nd0), 256'd0);

    // rerun "abc"
    issue(TB_IV, B_ABC, D_ABC);
    wait_done();

    // randomized back-to-back blocks
    prev = D_ABC;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("hold_prev", v_out, prev);
      rv = rnd256();
      rb = rnd512();
      e1 = cf(rv, rb);
      issue(rv, rb, e1);
      wait_done();
      prev = e1;
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 256'(q_exp.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
